imem_load_arbiter: RTL and testbench

Arbitration and sequencing controller in front of the 1024×32 instruction memory. It shares the single memory port between the CPU fetch stage and a program loader, such as a UART or debug bootloader, with the loader having priority. It holds the CPU while a new program image is streamed in, and returns fetched instructions one cycle after grant. It sits between the fetch stage and the instruction memory array, and the array's write port is driven only by this block.

---
 rtl/imem_pkg.sv | 10 +
 rtl/imem_load_seq.sv | 74 +++++++
 rtl/imem_load_arbiter.sv | 76 +++++++
 tb/tb_imem_load_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and state encoding for the instruction-memory load arbiter
package imem_pkg;
    localparam int IMEM_AW = 10;
    localparam int IMEM_DW = 32;
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } imem_state_e;
endpackage

// File: rtl/imem_load_seq.sv
// imem_load_seq: load sequencer (state, write pointer, word count, overflow flag, checksum); checksum built only with IMEM_LOAD_CSUM_EN
module imem_load_seq
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ld_start_i,
    input  logic        ld_valid_i,
    input  logic        ld_last_i,
`ifdef IMEM_LOAD_CSUM_EN
    input  logic [DW-1:0] ld_data_i,
`endif
    output imem_state_e   state_o,
    output logic [AW-1:0] ptr_o,
    output logic          wr_o,
    output logic          ld_done_o,
    output logic          ld_err_o,
    output logic [AW:0]   ld_count_o,
    output logic [DW-1:0] ld_csum_o
);
    imem_state_e state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic        err_q, err_d;
    logic        start, acc, full;
    // The count saturates at 2^AW, so its top bit alone marks a full memory;
    // the low bits double as the write pointer.
    assign full  = count_q[AW];
    assign start = (state_q == ST_RUN) && ld_start_i;
    assign acc   = (state_q == ST_LOAD) && ld_valid_i;
    assign wr_o  = acc && !full;
    // Next-state logic for the sequencer
    always_comb begin
        state_d = start ? ST_LOAD :
                  (acc && ld_last_i) ? ST_DONE :
                  (state_q == ST_DONE) ? ST_RUN : state_q;
        count_d = start ? '0 : wr_o ? count_q + 1'b1 : count_q;
        err_d   = start ? 1'b0 : (acc && full) ? 1'b1 : err_q;
    end
    // Sequencer state registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_RUN;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
`ifdef IMEM_LOAD_CSUM_EN
    logic [DW-1:0] csum_q, csum_d;
    // Running sum of words actually written; overflow words never reach memory and are skipped
    always_comb begin
        csum_d = start ? '0 : wr_o ? csum_q + ld_data_i : csum_q;
    end
    // Checksum register
    always_ff @(posedge clk or negedge res) begin
        if (!res) csum_q <= '0;
        else      csum_q <= csum_d;
    end
    assign ld_csum_o = csum_q;
`else
    assign ld_csum_o = '0;
`endif
    assign state_o    = state_q;
    assign ptr_o      = count_q[AW-1:0];
    assign ld_done_o  = (state_q == ST_DONE);
    assign ld_err_o   = err_q;
    assign ld_count_o = count_q;
endmodule

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the imem port between fetch and a priority program loader; IMEM_LOAD_CSUM_EN enables the load checksum
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_instr,
    output logic          cpu_hold,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_err,
    output logic [AW:0]   ld_count,
    output logic [DW-1:0] ld_csum,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    imem_state_e   state;
    logic [AW-1:0] ptr;
    logic          f_valid_q, f_valid_d;
    logic [DW-1:0] f_instr_q, f_instr_d;

    imem_load_seq #(.AW(AW), .DW(DW)) u_seq (
        .clk        (clk),
        .res        (res),
        .ld_start_i (ld_start),
        .ld_valid_i (ld_valid),
        .ld_last_i  (ld_last),
`ifdef IMEM_LOAD_CSUM_EN
        .ld_data_i  (ld_data),
`endif
        .state_o    (state),
        .ptr_o      (ptr),
        .wr_o       (mem_we),
        .ld_done_o  (ld_done),
        .ld_err_o   (ld_err),
        .ld_count_o (ld_count),
        .ld_csum_o  (ld_csum)
    );

    // Loader wins the port: a same-cycle ld_start blocks the fetch grant
    assign f_gnt     = (state == ST_RUN) && f_req && !ld_start;
    assign cpu_hold  = (state != ST_RUN);
    assign ld_ready  = (state == ST_LOAD);
    assign mem_addr  = (state == ST_LOAD) ? ptr : f_addr;
    assign mem_wdata = mem_we ? ld_data : '0;
    // Capture the granted word; f_instr keeps its last value between grants
    always_comb begin
        f_valid_d = f_gnt;
        f_instr_d = f_gnt ? mem_rdata : f_instr_q;
    end
    // Fetch output register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            f_valid_q <= 1'b0;
            f_instr_q <= '0;
        end else begin
            f_valid_q <= f_valid_d;
            f_instr_q <= f_instr_d;
        end
    end
    assign f_valid = f_valid_q;
    assign f_instr = f_instr_q;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: directed self-checking bench with a behavioural 1024x32 memory
module tb_imem_load_arbiter;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        f_req = 1'b0;
    logic [9:0]  f_addr = '0;
    logic        f_gnt, f_valid, cpu_hold;
    logic [31:0] f_instr;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_ready, ld_done, ld_err, mem_we;
    logic [10:0] ld_count;
    logic [31:0] ld_csum, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem [0:1023];
    int          n_chk = 0;
    int          n_err = 0;
    int          we_cnt;

    imem_load_arbiter dut (
        .clk(clk), .res(res), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_valid(f_valid), .f_instr(f_instr), .cpu_hold(cpu_hold),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .ld_count(ld_count),
        .ld_csum(ld_csum), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
        cyc();
        cyc();
        #1;
        check("rst_f_valid", f_valid, 0);
        check("rst_f_instr", f_instr, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_we", mem_we, 0);
        check("rst_count", ld_count, 0);
        check("rst_err", ld_err, 0);
        check("rst_csum", ld_csum, 0);
        check("rst_done", ld_done, 0);
        res = 1'b1;
        cyc();
        // fetch 5,6,7
        f_req = 1; f_addr = 10'd5; #1;
        check("f5_gnt", f_gnt, 1);
        check("f5_addr", mem_addr, 5);
        cyc();
        f_addr = 10'd6; #1;
        check("f5_valid", f_valid, 1);
        check("f5_instr", f_instr, 32'hC0DE0005);
        cyc();
        f_addr = 10'd7; #1;
        check("f6_instr", f_instr, 32'hC0DE0006);
        cyc();
        f_req = 0; #1;
        check("f7_valid", f_valid, 1);
        check("f7_instr", f_instr, 32'hC0DE0007);
        check("f7_hold", cpu_hold, 0);
        cyc();
        check("f_idle_valid", f_valid, 0);
        // 4-word load
        ld_start = 1; #1;
        check("l4_start_hold", cpu_hold, 0);
        cyc();
        ld_start = 0; #1;
        check("l4_hold", cpu_hold, 1);
        check("l4_ready", ld_ready, 1);
        check("l4_count0", ld_count, 0);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = 32'h11111111 * (i + 1); ld_last = (i == 3); #1;
            check("l4_we", mem_we, 1);
            check("l4_addr", mem_addr, i);
            check("l4_wdata", mem_wdata, 32'h11111111 * (i + 1));
            cyc();
        end
        ld_valid = 0; ld_last = 0; #1;
        check("l4_done", ld_done, 1);
        check("l4_done_hold", cpu_hold, 1);
        check("l4_count", ld_count, 4);
`ifdef IMEM_LOAD_CSUM_EN
        check("l4_csum", ld_csum, 32'hAAAAAAAA);
`else
        check("l4_csum", ld_csum, 0);
`endif
        cyc();
        check("l4_done_pulse", ld_done, 0);
        check("l4_run_hold", cpu_hold, 0);
        check("l4_mem0", mem[0], 32'h11111111);
        check("l4_mem3", mem[3], 32'h44444444);
        // grant then ld_start with f_req
        f_req = 1; f_addr = 10'd8; #1;
        check("s_gnt_pre", f_gnt, 1);
        cyc();
        ld_start = 1; f_addr = 10'd9; #1;
        check("s_gnt_start", f_gnt, 0);
        check("s_valid_start", f_valid, 1);
        check("s_instr_start", f_instr, 32'hC0DE0008);
        cyc();
        ld_start = 0; #1;
        check("s_load_gnt", f_gnt, 0);
        check("s_load_valid", f_valid, 0);
        ld_valid = 1; ld_last = 1; ld_data = 32'h55555555; #1;
        cyc();
        ld_valid = 0; ld_last = 0; #1;
        check("s_done", ld_done, 1);
        check("s_done_gnt", f_gnt, 0);
        check("s_done_valid", f_valid, 0);
        check("s_done_count", ld_count, 1);
        cyc();
        check("s_run_gnt", f_gnt, 1);
        check("s_run_valid", f_valid, 0);
        cyc();
        f_req = 0; #1;
        check("s_post_valid", f_valid, 1);
        check("s_post_instr", f_instr, 32'hC0DE0009);
        cyc();
        // 1025-word overflow load
        ld_start = 1; cyc();
        ld_start = 0;
        we_cnt = 0;
        for (int i = 0; i < 1025; i++) begin
            ld_valid = 1; ld_data = i; ld_last = (i == 1024); #1;
            if (mem_we) we_cnt++;
            if (i == 1023) check("ov_we_1023", mem_we, 1);
            if (i == 1024) begin
                check("ov_we_1024", mem_we, 0);
                check("ov_ready_1024", ld_ready, 1);
                check("ov_wdata_1024", mem_wdata, 0);
            end
            cyc();
        end
        ld_valid = 0; ld_last = 0; #1;
        check("ov_we_cnt", we_cnt, 1024);
        check("ov_err", ld_err, 1);
        check("ov_count", ld_count, 1024);
        check("ov_done", ld_done, 1);
        check("ov_mem1023", mem[1023], 32'd1023);
`ifdef IMEM_LOAD_CSUM_EN
        check("ov_csum", ld_csum, 32'h0007FE00);
`else
        check("ov_csum", ld_csum, 0);
`endif
        cyc();
        check("ov_err_sticky", ld_err, 1);
        ld_start = 1; cyc();
        ld_start = 0; #1;
        check("ov_err_clr", ld_err, 0);
        check("ov_count_clr", ld_count, 0);
        // gapped load, with an ignored ld_start mid-load
        for (int k = 0; k < 9; k++) begin
            ld_valid = (k % 3 == 2); ld_last = (k == 8); ld_data = 32'hD0 + k; ld_start = (k == 4); #1;
            check("g_we", mem_we, ld_valid);
            if (ld_valid) check("g_addr", mem_addr, k / 3);
            cyc();
        end
        ld_valid = 0; ld_last = 0; ld_start = 0; #1;
        check("g_done", ld_done, 1);
        check("g_count", ld_count, 3);
`ifdef IMEM_LOAD_CSUM_EN
        check("g_csum", ld_csum, 32'h27F);
`else
        check("g_csum", ld_csum, 0);
`endif
        cyc();
        check("g_mem0", mem[0], 32'hD2);
        check("g_mem1", mem[1], 32'hD5);
        check("g_mem2", mem[2], 32'hD8);
        check("g_mem3", mem[3], 32'd3);
        // reset mid-load
        ld_start = 1; cyc();
        ld_start = 0; ld_valid = 1; ld_data = 32'hAAAA0001; cyc();
        ld_data = 32'hAAAA0002; cyc();
        ld_valid = 0; #1;
        check("r_count2", ld_count, 2);
        check("r_hold_pre", cpu_hold, 1);
        res = 0; #1;
        check("r_hold", cpu_hold, 0);
        check("r_count", ld_count, 0);
        check("r_ready", ld_ready, 0);
        check("r_we", mem_we, 0);
        @(negedge clk);
        res = 1;
        f_req = 1; f_addr = 10'd1;
        cyc();
        check("r_mem0", mem[0], 32'hAAAA0001);
        check("r_mem1", mem[1], 32'hAAAA0002);
        check("r_gnt", f_gnt, 1);
        cyc();
        check("r_fetch1", f_instr, 32'hAAAA0002);
        f_req = 0;
        cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
